// File: rtl/seq_arith_unit.sv
// Multi-cycle unsigned SUB/MUL/DIV/MOD engine with valid/ready handshakes.
// MUL is shift-add (LSB first); DIV/MOD share one restoring divider (MSB first).
module seq_arith_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_SUB = 2'd0, OP_MUL = 2'd1, OP_DIV = 2'd2, OP_MOD = 2'd3} op_t;

  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  state_t           state;
  op_t              op_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] acc_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One iteration of each datapath; the dividend shifts out of quo as quotient bits shift in.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    fits    = (trial >= {2'b00, c_r});
    rem_nxt = fits ? (trial[WIDTH:0] - {1'b0, c_r}) : trial[WIDTH:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      result      <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r   <= op_t'(op);
            b_r    <= b;
            c_r    <= c;
            acc    <= '0;
            rem    <= '0;
            quo    <= b;
            mcand  <= b;
            mplier <= c;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (op_r == OP_SUB) begin
            result      <= b_r - c_r;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end else if (op_r != OP_MUL && c_r == '0) begin
            // Divide by zero short-circuits: DIV saturates, MOD returns the dividend.
            result      <= (op_r == OP_DIV) ? '1 : b_r;
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST_IT) begin
              div_by_zero <= 1'b0;
              cnt         <= '0;
              state       <= DONE;
              case (op_r)
                OP_MUL:  result <= acc_nxt;
                OP_DIV:  result <= quo_nxt;
                default: result <= rem_nxt[WIDTH-1:0];
              endcase
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised, multi-cycle unsigned arithmetic engine that executes SUB, MUL, DIV and MOD on registered operands. It uses a valid/ready handshake on both input and output. Combinational arithmetic is replaced by an iterative datapath: shift-add multiply and restoring divide. It sits between an operand-issue stage and a result consumer and handles one operation at a time.

Parameters:
WIDTH, 8, operand and result width in bits (legal values are 2 and above).
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operation request.
in_ready  out  1  unit can accept a request; high only in IDLE.
op  in  2  operation select: 0=SUB, 1=MUL, 2=DIV, 3=MOD.
b  in  WIDTH  first operand (minuend, multiplicand, dividend).
c  in  WIDTH  second operand (subtrahend, multiplier, divisor).
out_valid  out  1  result is available.
out_ready  in  1  consumer accepts the result.
result  out  WIDTH  operation result.
div_by_zero  out  1  the current result came from DIV or MOD with c==0.

Behaviour:
- Reset is synchronous on the clk edge while rst=1.
  - State goes to IDLE.
  - out_valid=0, result=0, div_by_zero=0, iteration counter=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides every other input, including mid-operation: the in-flight operation is discarded and no out_valid is produced for it.
- FSM states:
  - IDLE
    - in_ready=1.
    - If in_valid=1, latch op, b and c, clear the accumulators, and go to CALC.
    - Otherwise stay in IDLE.
  - CALC
    - in_ready=0.
    - Perform one iteration per cycle.
    - When the last iteration completes, load result and div_by_zero, then go to DONE.
  - DONE
    - out_valid=1; result and div_by_zero are held stable.
    - If out_ready=1, go to IDLE (out_valid=0 next cycle).
    - Otherwise stay in DONE indefinitely.
- Latency: with acceptance on edge N, out_valid rises after edge N+L.
  - SUB: L=1.
  - DIV or MOD with c==0: L=1.
  - MUL, DIV and MOD otherwise: L=WIDTH.
- The unit does not accept a new request in the same cycle a result is consumed. The minimum spacing is L+2 cycles.
- Arithmetic (all unsigned):
  - SUB: result = (b - c) mod 2^WIDTH; it wraps on underflow.
  - MUL: shift-add, one multiplier bit per cycle, LSB first. result = low WIDTH bits of b*c; the upper bits are discarded.
  - DIV: restoring division, one quotient bit per cycle, MSB first. result = floor(b/c).
  - MOD: the same datapath as DIV. result = b mod c (the final partial remainder).
  - The internal remainder register is WIDTH+1 bits so the trial subtract never overflows.
- Divide by zero (op=2 or 3, c==0):
  - Skip the iterations and go to DONE after 1 cycle.
  - DIV gives result = all ones. MOD gives result = b.
  - div_by_zero=1.
- div_by_zero=0 for every other operation.
- Operands and op may change freely after acceptance. Only the latched copies are used.
- in_valid while not in IDLE is ignored and not queued.
- result keeps its last value while in IDLE. Consumers use it only when out_valid=1.
- No latches and no combinational feedback. in_ready and out_valid are decoded from registered state only.

Test Plan:
- WIDTH=8, SUB b=5 c=7 -> out_valid 1 cycle after acceptance, result=8'hFE, div_by_zero=0.
- MUL b=20 c=13 -> out_valid after 8 cycles, result=8'h04 (260 truncated). Also MUL b=255 c=255 -> result=8'h01.
- DIV b=200 c=7 -> result=28 after 8 cycles. MOD with the same operands -> result=4. MOD b=6 c=9 -> result=6.
- DIV b=123 c=0 -> result=8'hFF, div_by_zero=1 after 1 cycle. MOD b=123 c=0 -> result=123, div_by_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: result stable, out_valid held, in_ready=0, and a second in_valid is ignored. Then raise out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst on cycle 4 of a MUL. Required: next cycle state is IDLE, out_valid=0, result=0. A following SUB 9-3 -> result=6.
